// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: reusable elastic pipeline-stage register.
// Carries a data and a control bundle. Optional skid entry for registered
// backpressure. Supports flush with bubble marking, occupancy reporting and
// a saturating count of entries killed by flush.
//
// Handshake: an entry moves across a boundary on a cycle where the producer's
// valid and the consumer's ready are both high at the rising edge. Upstream
// accept = i_valid && o_ready. Downstream drain = o_valid && i_ready. Once
// o_valid is high, o_data/o_ctrl hold until drained, flushed or reset.
`timescale 1ns/1ps
module pipe_stage_reg #(
  parameter int DATA_W         = 96,
  parameter int CTRL_W         = 16,
  parameter int SKID           = 1,
  parameter int FLUSH_CLR_DATA = 1,
  parameter int CNT_W          = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic              o_bubble,
  input  logic              i_ready,
  input  logic              i_flush,
  output logic [1:0]        o_count,
  output logic [CNT_W-1:0]  o_flush_drops
);

  // Main entry (drives the outputs) and skid entry (used only when SKID=1)
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic [CTRL_W-1:0] m_ctrl;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic [CTRL_W-1:0] s_ctrl;
  logic              bubble;
  logic [CNT_W-1:0]  drops;

  logic              accept;
  logic              drain;
  logic [1:0]        kill_n;
  logic [CNT_W:0]    drops_sum;

  // Ready, handshakes and flush-kill accounting.
  // In skid mode ready depends only on the registered skid valid, so there is
  // no combinational path from i_ready to o_ready.
  always_comb begin
    if (!i_reset) begin
      o_ready = 1'b1;
    end else if (SKID != 0) begin
      o_ready = !s_valid;
    end else begin
      o_ready = !m_valid || i_ready;
    end
    accept    = i_valid && o_ready;
    drain     = m_valid && i_ready;
    // A same-cycle drain completes downstream, so only held entries count.
    kill_n    = {1'b0, m_valid && !i_ready} + {1'b0, s_valid};
    drops_sum = {1'b0, drops} + (CNT_W+1)'(kill_n);
  end

  // Entry storage: reset > flush > normal movement (skid or single entry)
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_ctrl  <= '0;
      s_valid <= 1'b0;
      s_data  <= '0;
      s_ctrl  <= '0;
      bubble  <= 1'b0;
      drops   <= '0;
    end else if (i_flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      bubble  <= 1'b1;
      if (FLUSH_CLR_DATA != 0) begin
        m_data <= '0;
      end
      drops <= drops_sum[CNT_W] ? {CNT_W{1'b1}} : drops_sum[CNT_W-1:0];
    end else if (SKID != 0) begin
      if (drain && s_valid) begin
        // Skid entry advances; a new accept refills the skid slot.
        m_valid <= 1'b1;
        m_data  <= s_data;
        m_ctrl  <= s_ctrl;
        bubble  <= 1'b0;
        s_valid <= accept;
        if (accept) begin
          s_data <= i_data;
          s_ctrl <= i_ctrl;
        end
      end else if (drain || !m_valid) begin
        // Main slot is free this cycle: load it directly or go empty.
        m_valid <= accept;
        if (accept) begin
          m_data <= i_data;
          m_ctrl <= i_ctrl;
          bubble <= 1'b0;
        end
      end else if (accept) begin
        // Main is held: the accepted entry parks in the skid slot.
        s_valid <= 1'b1;
        s_data  <= i_data;
        s_ctrl  <= i_ctrl;
      end
    end else begin
      if (accept) begin
        m_valid <= 1'b1;
        m_data  <= i_data;
        m_ctrl  <= i_ctrl;
        bubble  <= 1'b0;
      end else if (drain) begin
        m_valid <= 1'b0;
      end
    end
  end

  // Output view of the main entry; control is masked when nothing is valid
  always_comb begin
    o_valid       = m_valid;
    o_data        = m_data;
    o_ctrl        = m_valid ? m_ctrl : '0;
    o_bubble      = bubble;
    o_count       = {1'b0, m_valid} + {1'b0, s_valid};
    o_flush_drops = drops;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed bench with scoreboard for pipe_stage_reg.
// Instance a: SKID=1, FLUSH_CLR_DATA=1, CNT_W=2. Instance b: SKID=0,
// FLUSH_CLR_DATA=0, CNT_W=2.
`timescale 1ns/1ps
module tb_pipe_stage_reg;
  localparam int DW = 16;
  localparam int CW = 4;
  localparam int W  = DW + CW;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic          a_valid, a_ready, a_ovalid, a_bubble, a_iready, a_flush;
  logic [DW-1:0] a_data, a_odata;
  logic [CW-1:0] a_ctrl, a_octrl;
  logic [1:0]    a_count, a_drops;

  logic          b_valid, b_ready, b_ovalid, b_bubble, b_iready, b_flush;
  logic [DW-1:0] b_data, b_odata;
  logic [CW-1:0] b_ctrl, b_octrl;
  logic [1:0]    b_count, b_drops;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] a_q[$];
  logic [W-1:0] b_q[$];

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .FLUSH_CLR_DATA(1), .CNT_W(2)) dut_a (
    .i_clk(clk), .i_reset(rst_n), .i_valid(a_valid), .i_data(a_data), .i_ctrl(a_ctrl),
    .o_ready(a_ready), .o_valid(a_ovalid), .o_data(a_odata), .o_ctrl(a_octrl),
    .o_bubble(a_bubble), .i_ready(a_iready), .i_flush(a_flush), .o_count(a_count),
    .o_flush_drops(a_drops)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .FLUSH_CLR_DATA(0), .CNT_W(2)) dut_b (
    .i_clk(clk), .i_reset(rst_n), .i_valid(b_valid), .i_data(b_data), .i_ctrl(b_ctrl),
    .o_ready(b_ready), .o_valid(b_ovalid), .o_data(b_odata), .o_ctrl(b_octrl),
    .o_bubble(b_bubble), .i_ready(b_iready), .i_flush(b_flush), .o_count(b_count),
    .o_flush_drops(b_drops)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: offer one entry for one cycle, check ready, record expected output
  task automatic a_send(input logic [DW-1:0] d, input logic [CW-1:0] c, input logic exp_acc);
    a_valid = 1'b1; a_data = d; a_ctrl = c;
    @(negedge clk);
    chk("a_send_ready", a_ready, exp_acc);
    if (exp_acc) a_q.push_back({c, d});
    tick();
    a_valid = 1'b0;
  endtask

  task automatic b_send(input logic [DW-1:0] d, input logic [CW-1:0] c, input logic exp_acc);
    b_valid = 1'b1; b_data = d; b_ctrl = c;
    @(negedge clk);
    chk("b_send_ready", b_ready, exp_acc);
    if (exp_acc) b_q.push_back({c, d});
    tick();
    b_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    a_q.delete();
    b_q.delete();
  endtask

  // Scoreboard monitor: compare every drained output against the queue head
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_ovalid && a_iready) begin
        if (a_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL a_out: got %0h expected no output", {a_octrl, a_odata});
        end else begin
          chk("a_out", {a_octrl, a_odata}, a_q.pop_front());
        end
      end else if (!a_ovalid) begin
        chk("a_ctrl_idle", a_octrl, 0);
      end
      if (b_ovalid && b_iready) begin
        if (b_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL b_out: got %0h expected no output", {b_octrl, b_odata});
        end else begin
          chk("b_out", {b_octrl, b_odata}, b_q.pop_front());
        end
      end else if (!b_ovalid) begin
        chk("b_ctrl_idle", b_octrl, 0);
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1);
  end

  logic [DW-1:0] sv[3];
  logic [1:0]    sat_exp[4];

  initial begin
    sv      = '{16'h0011, 16'h0022, 16'h0033};
    sat_exp = '{2'd2, 2'd3, 2'd3, 2'd3};
    a_flush = 0; a_iready = 1; a_ctrl = 4'hF;
    b_flush = 0; b_iready = 1; b_ctrl = 4'hF;
    a_valid = 1; a_data = 16'hAAAA;
    b_valid = 1; b_data = 16'hBBBB;
    rst_n = 0;

    // Reset held for two cycles with entries offered
    repeat (2) begin
      @(negedge clk);
      chk("rst_ready_a", a_ready, 1);
      chk("rst_ready_b", b_ready, 1);
      @(posedge clk);
    end
    #1;
    rst_n = 1; a_valid = 0; b_valid = 0;
    @(negedge clk);
    chk("rst_valid", a_ovalid, 0);
    chk("rst_ctrl", a_octrl, 0);
    chk("rst_data", a_odata, 0);
    chk("rst_bubble", a_bubble, 0);
    chk("rst_count", a_count, 0);
    chk("rst_drops", a_drops, 0);
    chk("rst_valid_b", b_ovalid, 0);
    tick();

    // Streaming 0x11, 0x22, 0x33 back to back
    for (int i = 0; i < 4; i++) begin
      a_valid = (i < 3);
      if (i < 3) a_data = sv[i];
      a_ctrl = CW'(i + 1);
      @(negedge clk);
      if (i < 3) begin
        chk("stream_ready", a_ready, 1);
        a_q.push_back({a_ctrl, a_data});
      end
      if (i > 0) chk("stream_data", a_odata, sv[i-1]);
      chk("stream_count", a_count, (i > 0) ? 1 : 0);
      tick();
    end
    a_valid = 0;
    @(negedge clk);
    chk("stream_empty", a_ovalid, 0);
    chk("stream_hold", a_odata, 16'h0033);
    tick();

    // Backpressure: A in M, B in S, C refused until space returns
    a_iready = 0; a_valid = 1; a_data = 16'h00A0; a_ctrl = 4'hA;
    @(negedge clk);
    chk("bp_ready_a", a_ready, 1);
    a_q.push_back({a_ctrl, a_data});
    tick();
    a_data = 16'h00B0; a_ctrl = 4'hB;
    @(negedge clk);
    chk("bp_ready_b", a_ready, 1);
    chk("bp_m_a", a_odata, 16'h00A0);
    a_q.push_back({a_ctrl, a_data});
    tick();
    a_data = 16'h00C0; a_ctrl = 4'hC;
    @(negedge clk);
    chk("bp_ready_c", a_ready, 0);
    chk("bp_count2", a_count, 2);
    chk("bp_m_held", a_odata, 16'h00A0);
    tick();
    a_iready = 1;
    @(negedge clk);
    chk("bp_ready_rise", a_ready, 0);
    tick();
    @(negedge clk);
    chk("bp_ready_back", a_ready, 1);
    chk("bp_m_b", a_odata, 16'h00B0);
    a_q.push_back({a_ctrl, a_data});
    tick();
    a_valid = 0;
    @(negedge clk);
    chk("bp_m_c", a_odata, 16'h00C0);
    tick();

    // Flush with two held entries and an offered entry D
    a_iready = 0;
    a_send(16'h00A1, 4'h1, 1);
    a_send(16'h00B2, 4'h2, 1);
    a_valid = 1; a_data = 16'h00D4; a_ctrl = 4'h4; a_flush = 1;
    @(negedge clk);
    chk("fl_count_pre", a_count, 2);
    tick();
    a_flush = 0; a_valid = 0; a_q.delete();
    @(negedge clk);
    chk("fl_valid", a_ovalid, 0);
    chk("fl_ctrl", a_octrl, 0);
    chk("fl_bubble", a_bubble, 1);
    chk("fl_count", a_count, 0);
    chk("fl_drops", a_drops, 2);
    chk("fl_data_clr", a_odata, 0);
    tick();
    a_iready = 1;
    a_send(16'h00E5, 4'h5, 1);
    @(negedge clk);
    chk("fl_bubble_clr", a_bubble, 0);
    tick();

    // Flush coinciding with a drain kills nothing
    a_send(16'h00F6, 4'h6, 1);
    a_flush = 1;
    tick();
    a_flush = 0;
    @(negedge clk);
    chk("fl_drain_drops", a_drops, 2);
    chk("fl_drain_bubble", a_bubble, 1);
    tick();

    // Reset mid-operation with held entries
    a_iready = 0;
    a_send(16'h00C1, 4'h1, 1);
    a_send(16'h00C2, 4'h2, 1);
    do_reset();
    @(negedge clk);
    chk("mid_rst_valid", a_ovalid, 0);
    chk("mid_rst_count", a_count, 0);
    chk("mid_rst_drops", a_drops, 0);
    tick();

    // Saturation of the 2-bit drop counter
    for (int i = 0; i < 4; i++) begin
      a_send(DW'(16'h0100 + i), 4'h1, 1);
      a_send(DW'(16'h0200 + i), 4'h2, 1);
      a_flush = 1;
      tick();
      a_flush = 0; a_q.delete();
      @(negedge clk);
      chk("sat_drops", a_drops, sat_exp[i]);
      tick();
    end
    a_iready = 1;

    // Reset after a flush clears bubble and the counter
    do_reset();
    @(negedge clk);
    chk("rst2_bubble", a_bubble, 0);
    chk("rst2_drops", a_drops, 0);
    tick();

    // Single-entry mode
    b_iready = 0;
    b_send(16'h0101, 4'h1, 1);
    b_valid = 1; b_data = 16'h0202; b_ctrl = 4'h2;
    @(negedge clk);
    chk("b_ready_hold", b_ready, 0);
    chk("b_count_1", b_count, 1);
    chk("b_m_x", b_odata, 16'h0101);
    tick();
    b_iready = 1;
    @(negedge clk);
    chk("b_ready_comb", b_ready, 1);
    b_q.push_back({b_ctrl, b_data});
    tick();
    b_data = 16'h0303; b_ctrl = 4'h3;
    @(negedge clk);
    chk("b_no_gap", b_odata, 16'h0202);
    chk("b_ready_stream", b_ready, 1);
    chk("b_count_max", b_count, 1);
    b_q.push_back({b_ctrl, b_data});
    tick();
    b_valid = 0;
    @(negedge clk);
    chk("b_m_z", b_odata, 16'h0303);
    tick();
    @(negedge clk);
    chk("b_empty", b_ovalid, 0);
    chk("b_empty_count", b_count, 0);
    chk("b_data_held", b_odata, 16'h0303);
    tick();
    b_iready = 0;
    b_send(16'h0404, 4'h4, 1);
    b_flush = 1;
    tick();
    b_flush = 0; b_q.delete();
    @(negedge clk);
    chk("b_fl_valid", b_ovalid, 0);
    chk("b_fl_data_held", b_odata, 16'h0404);
    chk("b_fl_bubble", b_bubble, 1);
    chk("b_fl_drops", b_drops, 1);
    tick();

    chk("a_q_empty", a_q.size(), 0);
    chk("b_q_empty", b_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline-stage register that replaces the fixed per-stage registers (IF/ID … MEM/WB) with one reusable block. It carries a data bundle and a control bundle, uses a valid/ready handshake in both directions, and optionally adds a skid entry so the stage can sustain full throughput with registered backpressure. It also supports flush with bubble marking, occupancy reporting, and a saturating count of flushed instructions for the performance counters.

## Interface
- DATA_W, 96: width of the data bundle (e.g. pc, alu_result, rdata).
- CTRL_W, 16: width of the control bundle (e.g. wb_en, mem_read, funct3). All bits are active-high enables or fields that are safe at zero.
- SKID, 1: 1 selects a 2-entry skid mode with registered o_ready. 0 selects a 1-entry mode with combinational o_ready.
- FLUSH_CLR_DATA, 1: 1 zeroes o_data on flush. 0 holds o_data on flush.
- CNT_W, 16: width of the flush-drop counter.
- i_clk  in  1  clock; all state updates on its rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_valid  in  1  upstream entry valid.
- i_data  in  DATA_W  upstream data.
- i_ctrl  in  CTRL_W  upstream control.
- o_ready  out  1  stage can accept an entry this cycle.
- o_valid  out  1  output entry valid.
- o_data  out  DATA_W  output data.
- o_ctrl  out  CTRL_W  output control. Forced to zero whenever o_valid=0.
- o_bubble  out  1  the output slot is empty because of a flush.
- i_ready  in  1  downstream accepts the output entry.
- i_flush  in  1  kill all held entries and any entry offered in the same cycle.
- o_count  out  2  number of held entries (0..2).
- o_flush_drops  out  CNT_W  saturating count of valid entries killed by flush.

## Operation
- Storage:
  - Main register (M) drives all o_* outputs.
  - Skid register (S) exists only when SKID=1.
  - Each entry carries a valid flag, data and control.
- Handshakes:
  - Accept happens when i_valid && o_ready.
  - Drain happens when o_valid && i_ready.
- Cycle priority: reset > flush > normal.
- Reset (i_reset=0) leaves: M and S empty, o_valid=0, o_data=0, o_ctrl=0, o_bubble=0, o_count=0, o_flush_drops=0.
  - o_ready=1 during reset cycles in both modes. Entries offered during reset are discarded.
- Flush (i_flush=1, i_reset=1):
  - Next cycle, M and S are empty, o_valid=0, o_ctrl=0, and o_bubble=1.
  - o_data becomes 0 if FLUSH_CLR_DATA=1; otherwise it is held.
  - Any same-cycle accept is discarded. A same-cycle drain still counts as completed downstream.
  - o_flush_drops increases by the number of held valid entries not drained that cycle (0, 1 or 2), saturating at 2^CNT_W−1.
- Normal operation, SKID=1:
  - o_ready = !S.valid, taken straight from a register with no combinational path from i_ready.
  - If M is empty, or M drains this cycle and S is empty, the accepted entry loads M.
  - If M is held (valid and not draining), the accepted entry loads S.
  - If M drains and S is valid, S moves to M. A new accept in that cycle loads S.
  - Order is FIFO; entries are never reordered or duplicated.
- Normal operation, SKID=0:
  - o_ready = !M.valid || i_ready (combinational).
  - An accept loads M. A drain with no accept empties M.
- When M empties without a refill: o_valid=0, o_ctrl=0, o_data held, o_bubble unchanged.
- Loading any entry into M clears o_bubble.
- o_count = M.valid + S.valid. It is always ≤1 when SKID=0.

## Timing
- Latency: an entry accepted in cycle N appears on o_* in cycle N+1 when M is free.
- Throughput: 1 entry per cycle in both modes while i_ready=1.
- Backpressure in SKID=1:
  - i_ready falls in cycle N.
  - One more entry can be accepted in cycle N (it goes to S).
  - o_ready=0 from cycle N+1.
  - After i_ready rises again, o_ready returns to 1 one cycle after S moves to M.
- o_valid and o_data stay stable while o_valid=1 and i_ready=0; the stage never withdraws an offered entry except on flush or reset.
- Flush takes effect at the next edge. o_ready in the flush cycle follows the normal equations, but the accept is discarded.
- Reset mid-operation discards all entries and resets o_flush_drops at that edge. o_bubble is not set by reset.

## Test plan
- Reset: hold i_reset=0 for 2 cycles with i_valid=1 → o_valid=0, o_ctrl=0, o_data=0, o_bubble=0, o_count=0, o_flush_drops=0.
- Streaming, SKID=1: send entries with data 0x11, 0x22, 0x33 back to back, i_ready=1 → o_data shows 0x11, 0x22, 0x33 in cycles N+1..N+3; o_ready stays 1; o_count stays ≤1.
- Backpressure, SKID=1:
  - i_ready=0 while sending A, B, C → A is in M, B is in S, o_ready=0 from the cycle after B, C is not accepted, o_count=2.
  - Raising i_ready → A then B drain, o_ready returns to 1, then C is accepted.
- Flush: with A and B held and i_ready=0, assert i_flush together with i_valid=1 (entry D) → next cycle o_valid=0, o_ctrl=0, o_bubble=1, o_count=0, o_flush_drops=2, and D is never output. A new load then clears o_bubble.
- Saturation: CNT_W=2, four flushes each with 2 entries held → o_flush_drops reads 2, then 3, then 3, then 3.
- SKID=0: with M valid and i_ready=1, o_ready=1 in the same cycle and a new entry replaces M with no gap; with i_ready=0, o_ready=0 and M is held; o_count never exceeds 1.
